// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// Master drives the request side; slave is the arithmetic unit.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             Ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Sub,
    input  S, Co, Ovf, busy, done
  );

  modport slave (
    input  start, A, B, Sub,
    output S, Co, Ovf, busy, done
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock, LSB first, with start/busy/done handshake.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_sub_if.slave  io
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_msb_in;
  logic             c_out;

  logic             sum_bit;
  logic             carry_nx;
  logic             last;
  logic             accept;

  assign sum_bit  = op_a[0] ^ op_b[0] ^ carry;
  assign carry_nx = (op_a[0] & op_b[0]) |
                    (op_a[0] & carry) |
                    (op_b[0] & carry);
  assign acc_nx   = {sum_bit, acc};
  assign last     = (cnt == CW'(WIDTH - 1));
  assign accept   = io.start & (state != RUN);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (io.start) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = io.start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      s_q      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      c_out    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        // Subtract as A + ~B + 1: the +1 rides in as the initial carry.
        op_a  <= io.A;
        op_b  <= io.Sub ? ~io.B : io.B;
        carry <= io.Sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        acc   <= acc_nx[WIDTH-1:1];
        carry <= carry_nx;
        cnt   <= cnt + CW'(1);
        if (last) begin
          s_q      <= acc_nx;
          c_msb_in <= carry;
          c_out    <= carry_nx;
        end
      end
    end
  end

  assign io.S    = s_q;
  assign io.Co   = c_out;
  assign io.Ovf  = c_msb_in ^ c_out;
  assign io.busy = (state == RUN);
  assign io.done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed vectors at WIDTH=8 plus random
// regression at WIDTH=2/8/32 against an arithmetic reference model.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   armed = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_sub_if #(.WIDTH(2))  b2 ();
  serial_add_sub_if #(.WIDTH(8))  b8 ();
  serial_add_sub_if #(.WIDTH(32)) b32 ();

  serial_add_sub #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .io(b2));
  serial_add_sub #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .io(b8));
  serial_add_sub #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .io(b32));

  // t = -1 idle, 0..w-1 busy, w = done cycle
  typedef struct packed {
    int          t;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] s;
    logic        co;
    logic        ovf;
  } mst_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  mst_t m2, m8, m32;

  function automatic mst_t mstep(mst_t m, logic rst, logic st,
                                 logic [63:0] a, logic [63:0] b,
                                 logic sub, int w);
    mst_t        n;
    logic [63:0] mask;
    logic [63:0] r;
    logic        sa, sb, sr;
    n    = m;
    mask = (64'd1 << w) - 64'd1;
    if (!rst) begin
      n   = '0;
      n.t = -1;
    end else if (m.t >= 0 && m.t < w) begin
      n.t = m.t + 1;
      if (n.t == w) begin
        if (m.sub) r = (m.a - m.b) & mask;
        else       r = (m.a + m.b) & mask;
        n.s  = r;
        n.co = m.sub ? (m.a >= m.b) : (((m.a + m.b) >> w) != 64'd0);
        sa   = m.a[w-1];
        sb   = m.b[w-1];
        sr   = r[w-1];
        n.ovf = m.sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
      end
    end else if (st) begin
      n.t   = 0;
      n.a   = a & mask;
      n.b   = b & mask;
      n.sub = sub;
    end else begin
      n.t = -1;
    end
    return n;
  endfunction

  function automatic logic [67:0] expv(mst_t m, int w);
    return {(m.t >= 0 && m.t < w), (m.t == w), m.ovf, m.co, m.s};
  endfunction

  task automatic chk(input string nm, input logic [67:0] got,
                     input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    m2  <= mstep(m2, rst_n, b2.start, 64'(b2.A), 64'(b2.B), b2.Sub, 2);
    m8  <= mstep(m8, rst_n, b8.start, 64'(b8.A), 64'(b8.B), b8.Sub, 8);
    m32 <= mstep(m32, rst_n, b32.start, 64'(b32.A), 64'(b32.B),
                 b32.Sub, 32);
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("mon2", {b2.busy, b2.done, b2.Ovf, b2.Co, 62'd0, b2.S},
          expv(m2, 2));
      chk("mon8", {b8.busy, b8.done, b8.Ovf, b8.Co, 56'd0, b8.S},
          expv(m8, 8));
      chk("mon32", {b32.busy, b32.done, b32.Ovf, b32.Co, 32'd0, b32.S},
          expv(m32, 32));
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input logic sub, output int t0);
    @(negedge clk);
    b8.A     = a;
    b8.B     = b;
    b8.Sub   = sub;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done8(input int t0, output int dt);
    while (!b8.done && (cyc - t0) < 40) @(negedge clk);
    dt = cyc - t0;
    chk("done8", 68'(b8.done), 68'(1));
  endtask

  function automatic logic [67:0] res8();
    return 68'({b8.Ovf, b8.Co, b8.S});
  endfunction

  vec_t tbl [5] = '{
    '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int dt;
    int d1;
    int dn;
    b2.start = 0; b2.A = '0; b2.B = '0; b2.Sub = 0;
    b8.start = 0; b8.A = '0; b8.B = '0; b8.Sub = 0;
    b32.start = 0; b32.A = '0; b32.B = '0; b32.Sub = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b1;
    chk("rst_state", 68'({b8.busy, b8.done, b8.Ovf, b8.Co, b8.S}), 68'(0));

    foreach (tbl[i]) begin
      go8(tbl[i].a, tbl[i].b, tbl[i].sub, t0);
      wait_done8(t0, dt);
      chk("lat", 68'(dt), 68'(8));
      chk("vec", res8(),
          68'({tbl[i].ovf, tbl[i].co, tbl[i].s}));
    end

    // stray starts on cycles 3 and 5 with other operands
    go8(8'h33, 8'h11, 1'b0, t0);
    repeat (2) @(negedge clk);
    b8.A = 8'hFF; b8.B = 8'hFF; b8.Sub = 1'b1; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    @(negedge clk);
    b8.A = 8'hC0; b8.B = 8'h40; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8(t0, dt);
    chk("ign_lat", 68'(dt), 68'(8));
    chk("ign_res", res8(), 68'({1'b0, 1'b0, 8'h44}));

    // start held through DONE
    @(negedge clk);
    b8.A = 8'h01; b8.B = 8'h02; b8.Sub = 1'b0; b8.start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    wait_done8(t0, dt);
    chk("b2b_res1", res8(), 68'({1'b0, 1'b0, 8'h03}));
    d1 = cyc;
    b8.A = 8'h70; b8.B = 8'h05; b8.Sub = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    chk("b2b_hold", 68'({b8.busy, b8.Co, b8.S}), 68'({1'b1, 1'b0, 8'h03}));
    wait_done8(d1, dt);
    chk("b2b_gap", 68'(dt), 68'(9));
    chk("b2b_res2", res8(), 68'({1'b0, 1'b1, 8'h6B}));

    // reset on cycle 4 of a run
    go8(8'h5A, 8'h3C, 1'b0, t0);
    while ((cyc - t0) < 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", 68'({b8.busy, b8.done, b8.Ovf, b8.Co, b8.S}), 68'(0));
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.done) dn++;
    end
    chk("rst_nodone", 68'(dn), 68'(0));
    go8(8'h7F, 8'h01, 1'b0, t0);
    wait_done8(t0, dt);
    chk("post_rst_lat", 68'(dt), 68'(8));
    chk("post_rst_res", res8(), 68'({1'b1, 1'b0, 8'h80}));

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          b2.A = 2'($urandom); b2.B = 2'($urandom);
          b2.Sub = 1'($urandom); b2.start = 1'b1;
          @(negedge clk);
          b2.start = 1'b0;
          for (int k = 0; k < 8 && !b2.done; k++) @(negedge clk);
          chk("rnd2_done", 68'(b2.done), 68'(1));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          b8.A = 8'($urandom); b8.B = 8'($urandom);
          b8.Sub = 1'($urandom); b8.start = 1'b1;
          @(negedge clk);
          b8.start = 1'b0;
          for (int k = 0; k < 16 && !b8.done; k++) @(negedge clk);
          chk("rnd8_done", 68'(b8.done), 68'(1));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          b32.A = $urandom; b32.B = $urandom;
          b32.Sub = 1'($urandom); b32.start = 1'b1;
          @(negedge clk);
          b32.start = 1'b0;
          for (int k = 0; k < 40 && !b32.done; k++) @(negedge clk);
          chk("rnd32_done", 68'(b32.done), 68'(1));
        end
      end
    join

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor, parametrised in operand width.
- Reuses a single 1-bit full-adder cell plus a carry flip-flop, processing one bit per clock, LSB first.
- Start/busy/done handshake; result held until the next operation completes.
- Used where area matters more than latency, and as the sequential successor to the combinational 1-bit full adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- Sub  input  1  0 = A+B, 1 = A-B; captured on accepted start
- S  output  WIDTH  result
- Co  output  1  final carry; for Sub, 1 = no borrow (A >= B unsigned)
- Ovf  output  1  two's-complement signed overflow
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, S=0, Co=0, Ovf=0, busy=0, done=0. Internal shift registers, carry and bit counter are cleared.
- Reset has priority over all other inputs. Asserting it mid-operation aborts the operation: no done pulse, and S/Co/Ovf are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → RUN.
  - Latch opA=A and opB = Sub ? ~B : B.
  - Set carry=Sub and bit counter=0.
  - busy=1 from the next cycle.
- RUN, one bit per edge:
  - sum_i = opA[0] ^ opB[0] ^ carry.
  - carry_next = majority(opA[0], opB[0], carry).
  - sum_i shifts into the MSB of the internal result shift register; opA and opB shift right by 1.
  - Counter increments.
  - On the edge that processes bit WIDTH-1: capture carry into the MSB (c_msb_in) and final carry_next (c_out), then go to DONE.
- DONE (exactly one cycle):
  - S = result register, Co = c_out, Ovf = c_msb_in ^ c_out.
  - done=1, busy=0.
  - Next edge → IDLE, unless start=1, in which case a new operation is accepted exactly as from IDLE (back-to-back).
- Latency: start accepted at edge 0 → bits processed at edges 1..WIDTH → done=1 during the cycle following edge WIDTH.
  - Throughput: one operation per WIDTH+1 cycles.
- busy=1 only in RUN. start while busy=1 is ignored: no queuing, no effect on the operation in flight.
- Output hold: S, Co and Ovf update only on entry to DONE. They hold their previous values through IDLE and RUN of the next operation.
- Operand changes on A/B/Sub after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Counter width is clog2(WIDTH)+1 bits; it must not wrap before reaching WIDTH-1.
- WIDTH=2 must work; there are no special cases for the minimum width.

Test Plan:
- Add, WIDTH=8: A=0x5A, B=0x3C, Sub=0 → done exactly 8 cycles after the start edge; S=0x96, Co=0, Ovf=1.
- Carry wrap: A=0xFF, B=0x01, Sub=0 → S=0x00, Co=1, Ovf=0. Then A=0x10, B=0x20, Sub=1 → S=0xF0, Co=0 (borrow), Ovf=0.
- Signed-overflow subtract: A=0x80, B=0x01, Sub=1 → S=0x7F, Co=1, Ovf=1. Also A=0x00, B=0x00, Sub=1 → S=0x00, Co=1, Ovf=0.
- Handshake:
  - Pulse start again on cycles 3 and 5 of a run, with different A/B → ignored; result matches the first operands.
  - start held high through the DONE cycle → second operation accepted immediately; done pulses are WIDTH+1 cycles apart.
  - S holds the old value until the second done.
- Reset mid-operation: rst_n=0 on cycle 4 of a run → next cycle S=0, Co=0, Ovf=0, busy=0, done=0; no done pulse follows. A new start after release completes normally.
- Random regression, WIDTH=2, 8 and 32: 1000 random A/B/Sub each → S, Co and Ovf match a reference model of A±B. done is one cycle wide and busy is never high together with done.
